// File: rtl/etapa_mem_wait_if.sv
// Bus bundle between the EX/MEM register and the MEM stage: pipeline controls,
// data memory access fields, registered MEM/WB outputs and the debug read port.
interface etapa_mem_wait_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  i_halt;
  logic [4:0]            i_write_reg;
  logic [31:0]           i_store_data;
  logic [31:0]           i_ALU_result;
  logic                  i_WB_write;
  logic                  i_WB_mem_to_reg;
  logic                  i_MEM_read;
  logic                  i_MEM_write;
  logic                  i_MEM_unsigned;
  logic [1:0]            i_MEM_byte_half_word;
  logic [ADDR_WIDTH-3:0] i_dbg_word_addr;

  logic                  o_WB_write;
  logic                  o_WB_mem_to_reg;
  logic [31:0]           o_ALU_result;
  logic [31:0]           o_read_data;
  logic [4:0]            o_write_reg;
  logic                  o_stall;
  logic                  o_misaligned;
  logic [31:0]           o_dbg_data;

  modport slave (
    input  i_halt, i_write_reg, i_store_data, i_ALU_result, i_WB_write,
           i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned,
           i_MEM_byte_half_word, i_dbg_word_addr,
    output o_WB_write, o_WB_mem_to_reg, o_ALU_result, o_read_data,
           o_write_reg, o_stall, o_misaligned, o_dbg_data
  );

  modport master (
    output i_halt, i_write_reg, i_store_data, i_ALU_result, i_WB_write,
           i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned,
           i_MEM_byte_half_word, i_dbg_word_addr,
    input  o_WB_write, o_WB_mem_to_reg, o_ALU_result, o_read_data,
           o_write_reg, o_stall, o_misaligned, o_dbg_data
  );
endinterface

// File: rtl/etapa_mem_wait.sv
// MIPS MEM stage with byte-lane data memory, sub-word loads, misalignment
// detection, a wait-state FSM for slow memories and a debug read port.
module etapa_mem_wait #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  etapa_mem_wait_if.slave bus
);

  localparam int         DEPTH      = 1 << (ADDR_WIDTH - 2);
  localparam bit         SLOW       = (LATENCY > 0);
  localparam logic [3:0] LAT_RELOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic [31:0] r_mem [DEPTH];

  logic        r_WB_write;
  logic        r_WB_mem_to_reg;
  logic [31:0] r_ALU_result;
  logic [31:0] r_read_data;
  logic [4:0]  r_write_reg;
  logic        r_misaligned;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-3:0] w_word;
  logic [1:0]            w_off;
  logic                  w_is_byte;
  logic                  w_is_half;
  logic                  w_req;
  logic                  w_misaligned;
  logic                  w_access;
  logic                  w_load_outputs;
  logic                  w_mem_we;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rword;
  logic [7:0]            w_rbyte;
  logic [15:0]           w_rhalf;
  logic [31:0]           w_load;

  assign w_addr    = bus.i_ALU_result[ADDR_WIDTH-1:0];
  assign w_word    = w_addr[ADDR_WIDTH-1:2];
  assign w_off     = w_addr[1:0];
  assign w_is_byte = (bus.i_MEM_byte_half_word == 2'b00);
  assign w_is_half = (bus.i_MEM_byte_half_word == 2'b01);
  assign w_req     = bus.i_MEM_read | bus.i_MEM_write;

  // Code 2'b10 falls into the word case, so it needs full alignment too.
  assign w_misaligned = w_req & ((w_is_half & w_off[0]) |
                                 (!w_is_byte && !w_is_half && (w_off != 2'b00)));
  assign w_access     = w_req & ~w_misaligned;

  // Output registers load on commit edges and on every cycle with no access pending.
  assign w_load_outputs = SLOW ? (((r_state == IDLE) && !w_access) ||
                                  ((r_state == BUSY) && (r_count == 4'd0)))
                               : 1'b1;
  assign w_mem_we = w_access & w_load_outputs & bus.i_MEM_write &
                    ~bus.i_halt & i_reset_n;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.i_store_data;
    if (w_is_byte) begin
      w_be[w_off] = 1'b1;
      w_wdata     = {4{bus.i_store_data[7:0]}};
    end else if (w_is_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{bus.i_store_data[15:0]}};
    end else begin
      w_be = 4'b1111;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_word][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_word];
  assign w_rbyte = w_rword[8*w_off +: 8];
  assign w_rhalf = w_off[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load = w_rword;
    if (w_is_byte) begin
      w_load = bus.i_MEM_unsigned ? {24'd0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
    end else if (w_is_half) begin
      w_load = bus.i_MEM_unsigned ? {16'd0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= IDLE;
      r_count         <= 4'd0;
      r_WB_write      <= 1'b0;
      r_WB_mem_to_reg <= 1'b0;
      r_ALU_result    <= 32'd0;
      r_read_data     <= 32'd0;
      r_write_reg     <= 5'd0;
      r_misaligned    <= 1'b0;
    end else if (!bus.i_halt) begin
      if (w_load_outputs) begin
        r_WB_write      <= bus.i_WB_write & ~w_misaligned;
        r_WB_mem_to_reg <= bus.i_WB_mem_to_reg;
        r_ALU_result    <= bus.i_ALU_result;
        r_read_data     <= w_load;
        r_write_reg     <= bus.i_write_reg;
        r_misaligned    <= w_misaligned;
      end else begin
        r_WB_write   <= 1'b0;
        r_misaligned <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (SLOW && w_access) begin
            r_state <= BUSY;
            r_count <= LAT_RELOAD;
          end
        end
        BUSY: begin
          if (r_count == 4'd0) r_state <= IDLE;
          else                 r_count <= r_count - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_WB_write      = r_WB_write;
  assign bus.o_WB_mem_to_reg = r_WB_mem_to_reg;
  assign bus.o_ALU_result    = r_ALU_result;
  assign bus.o_read_data     = r_read_data;
  assign bus.o_write_reg     = r_write_reg;
  assign bus.o_misaligned    = r_misaligned;
  assign bus.o_stall         = (r_state == BUSY);
  assign bus.o_dbg_data      = r_mem[bus.i_dbg_word_addr];

endmodule

// File: tb/tb_etapa_mem_wait.sv
// Scoreboard bench for etapa_mem_wait: a single-cycle instance (LATENCY=0) and a
// wait-state instance (LATENCY=3) share the clock but have separate buses/resets.
module tb_etapa_mem_wait;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst3_n;
  int   testsRun  = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  etapa_mem_wait_if #(.ADDR_WIDTH(12)) bus0 ();
  etapa_mem_wait_if #(.ADDR_WIDTH(12)) bus3 ();

  etapa_mem_wait #(.ADDR_WIDTH(12), .LATENCY(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst0_n), .bus(bus0)
  );
  etapa_mem_wait #(.ADDR_WIDTH(12), .LATENCY(3)) dut3 (
    .i_clk(clk), .i_reset_n(rst3_n), .bus(bus3)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          chkData;
    logic        wb;
    logic        mtr;
    logic        mis;
    logic [31:0] alu;
    logic [4:0]  wreg;
    int          stalls;
  } exp_t;

  exp_t expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic setInputs(input bit slow, input logic rd, input logic wr, input logic uns,
                           input logic [1:0] bhw, input logic [31:0] addr,
                           input logic [31:0] data, input logic wb, input logic [4:0] wreg);
    if (slow) begin
      bus3.i_MEM_read = rd;   bus3.i_MEM_write = wr;   bus3.i_MEM_unsigned = uns;
      bus3.i_MEM_byte_half_word = bhw;  bus3.i_ALU_result = addr;
      bus3.i_store_data = data; bus3.i_WB_write = wb;  bus3.i_WB_mem_to_reg = ~rd;
      bus3.i_write_reg = wreg;
    end else begin
      bus0.i_MEM_read = rd;   bus0.i_MEM_write = wr;   bus0.i_MEM_unsigned = uns;
      bus0.i_MEM_byte_half_word = bhw;  bus0.i_ALU_result = addr;
      bus0.i_store_data = data; bus0.i_WB_write = wb;  bus0.i_WB_mem_to_reg = ~rd;
      bus0.i_write_reg = wreg;
    end
  endtask

  task automatic checkResetState(input bit slow, input string tag);
    checkOutput({tag, " stall"},   slow ? bus3.o_stall        : bus0.o_stall,        0);
    checkOutput({tag, " wb"},      slow ? bus3.o_WB_write     : bus0.o_WB_write,     0);
    checkOutput({tag, " mtr"},     slow ? bus3.o_WB_mem_to_reg: bus0.o_WB_mem_to_reg,0);
    checkOutput({tag, " alu"},     slow ? bus3.o_ALU_result   : bus0.o_ALU_result,   0);
    checkOutput({tag, " rdata"},   slow ? bus3.o_read_data    : bus0.o_read_data,    0);
    checkOutput({tag, " wreg"},    slow ? bus3.o_write_reg    : bus0.o_write_reg,    0);
    checkOutput({tag, " mis"},     slow ? bus3.o_misaligned   : bus0.o_misaligned,   0);
  endtask

  // Drives one instruction, queues its expected result, waits (bounded) for the
  // commit edge, optionally pulsing halt for 2 cycles, then pops and compares.
  task automatic applyStimulus(input bit slow, input string tag, input logic rd, input logic wr,
                               input logic uns, input logic [1:0] bhw, input logic [31:0] addr,
                               input logic [31:0] data, input logic wb, input logic [4:0] wreg,
                               input logic [31:0] expData, input bit chkData, input logic expMis,
                               input int haltAt);
    exp_t e;
    int   n = 0;
    bit   done = 0;
    setInputs(slow, rd, wr, uns, bhw, addr, data, wb, wreg);
    e.tag = tag;  e.rdata = expData;  e.chkData = chkData;  e.wb = wb & ~expMis;
    e.mtr = ~rd;  e.mis = expMis;     e.alu = addr;         e.wreg = wreg;
    e.stalls = ((rd | wr) && !expMis && slow) ? (3 + ((haltAt >= 0) ? 2 : 0)) : 0;
    expQ.push_back(e);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (!(slow ? bus3.o_stall : bus0.o_stall)) begin
        done = 1;
        break;
      end
      n++;
      checkOutput({tag, " bubble wb"}, slow ? bus3.o_WB_write : bus0.o_WB_write, 0);
      if (haltAt >= 0 && n == haltAt)     bus3.i_halt = 1'b1;
      if (haltAt >= 0 && n == haltAt + 2) bus3.i_halt = 1'b0;
    end
    if (!done) checkOutput({tag, " commit timeout"}, 0, 1);
    e = expQ.pop_front();
    checkOutput({e.tag, " stall cycles"}, n, e.stalls);
    checkOutput({e.tag, " wb"},   slow ? bus3.o_WB_write      : bus0.o_WB_write,      e.wb);
    checkOutput({e.tag, " mis"},  slow ? bus3.o_misaligned    : bus0.o_misaligned,    e.mis);
    checkOutput({e.tag, " mtr"},  slow ? bus3.o_WB_mem_to_reg : bus0.o_WB_mem_to_reg, e.mtr);
    checkOutput({e.tag, " alu"},  slow ? bus3.o_ALU_result    : bus0.o_ALU_result,    e.alu);
    checkOutput({e.tag, " wreg"}, slow ? bus3.o_write_reg     : bus0.o_write_reg,     e.wreg);
    if (e.chkData)
      checkOutput({e.tag, " rdata"}, slow ? bus3.o_read_data : bus0.o_read_data, e.rdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    bus0.i_halt = 1'b0;  bus3.i_halt = 1'b0;
    bus0.i_dbg_word_addr = '0;  bus3.i_dbg_word_addr = '0;
    setInputs(0, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    setInputs(1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    #2;
    checkResetState(0, "reset0");
    checkResetState(1, "reset3");
    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    rst3_n = 1'b1;

    // Single-cycle instance: word round trip, sub-word stores and loads.
    applyStimulus(0, "SW 10",  0, 1, 0, 2'b11, 32'h10, 32'hA1B2C3D4, 0, 5'd0, 0, 0, 0, -1);
    applyStimulus(0, "LW 10",  1, 0, 0, 2'b11, 32'h10, 0, 1, 5'd3, 32'hA1B2C3D4, 1, 0, -1);
    applyStimulus(0, "SW 10b", 0, 1, 0, 2'b11, 32'h10, 32'h11223344, 0, 5'd0, 0, 0, 0, -1);
    applyStimulus(0, "SB 13",  0, 1, 0, 2'b00, 32'h13, 32'hFFFFFF80, 0, 5'd0, 0, 0, 0, -1);
    applyStimulus(0, "LW 10c", 1, 0, 0, 2'b11, 32'h10, 0, 1, 5'd4, 32'h80223344, 1, 0, -1);
    applyStimulus(0, "LW10 bhw10", 1, 0, 0, 2'b10, 32'h10, 0, 1, 5'd4, 32'h80223344, 1, 0, -1);
    applyStimulus(0, "LB 13",  1, 0, 0, 2'b00, 32'h13, 0, 1, 5'd5, 32'hFFFFFF80, 1, 0, -1);
    applyStimulus(0, "LBU 13", 1, 0, 1, 2'b00, 32'h13, 0, 1, 5'd6, 32'h00000080, 1, 0, -1);
    applyStimulus(0, "LB 11",  1, 0, 0, 2'b00, 32'h11, 0, 1, 5'd6, 32'h00000033, 1, 0, -1);
    applyStimulus(0, "LHU 12", 1, 0, 1, 2'b01, 32'h12, 0, 1, 5'd7, 32'h00008022, 1, 0, -1);
    applyStimulus(0, "LH 12",  1, 0, 0, 2'b01, 32'h12, 0, 1, 5'd7, 32'hFFFF8022, 1, 0, -1);
    applyStimulus(0, "LH 10",  1, 0, 0, 2'b01, 32'h10, 0, 1, 5'd8, 32'h00003344, 1, 0, -1);

    // Misalignment: no write, one-cycle pulse, WB suppressed.
    bus0.i_dbg_word_addr = 10'd1;
    applyStimulus(0, "SW 04",     0, 1, 0, 2'b11, 32'h04, 32'h12345678, 0, 5'd0, 0, 0, 0, -1);
    applyStimulus(0, "misLW 06",  1, 0, 0, 2'b11, 32'h06, 0, 1, 5'd9, 0, 0, 1, -1);
    applyStimulus(0, "idle",      0, 0, 0, 2'b11, 32'h0, 0, 0, 5'd0, 0, 0, 0, -1);
    applyStimulus(0, "misSW 05",  0, 1, 0, 2'b11, 32'h05, 32'hDEADBEEF, 0, 5'd0, 0, 0, 1, -1);
    applyStimulus(0, "misSH 05",  0, 1, 0, 2'b01, 32'h05, 32'hDEADBEEF, 0, 5'd0, 0, 0, 1, -1);
    checkOutput("dbg word1 after misaligned", bus0.o_dbg_data, 32'h12345678);
    applyStimulus(0, "LW 04",     1, 0, 0, 2'b11, 32'h04, 0, 1, 5'd10, 32'h12345678, 1, 0, -1);
    applyStimulus(0, "SH 06",     0, 1, 0, 2'b01, 32'h06, 32'hFFFFBEEF, 0, 5'd0, 0, 0, 0, -1);
    applyStimulus(0, "LW 04b",    1, 0, 0, 2'b11, 32'h04, 0, 1, 5'd11, 32'hBEEF5678, 1, 0, -1);

    // Address wrap plus debug port showing old contents until the store edge.
    setInputs(0, 0, 1, 0, 2'b11, 32'h1004, 32'h00000055, 0, 5'd0);
    #1;
    checkOutput("dbg old during store", bus0.o_dbg_data, 32'hBEEF5678);
    applyStimulus(0, "SW 1004",   0, 1, 0, 2'b11, 32'h1004, 32'h00000055, 0, 5'd0, 0, 0, 0, -1);
    checkOutput("dbg wrap word1", bus0.o_dbg_data, 32'h00000055);
    setInputs(0, 0, 0, 0, 2'b11, 0, 0, 0, 0);

    // Wait-state instance: 3 stall cycles per access, then halt stretching.
    bus3.i_dbg_word_addr = 10'd8;
    applyStimulus(1, "L3 SW 20",  0, 1, 0, 2'b11, 32'h20, 32'hCAFEF00D, 0, 5'd0, 0, 0, 0, -1);
    applyStimulus(1, "L3 LW 20",  1, 0, 0, 2'b11, 32'h20, 0, 1, 5'd7, 32'hCAFEF00D, 1, 0, -1);
    applyStimulus(1, "L3 LBU 21 halt", 1, 0, 1, 2'b00, 32'h21, 0, 1, 5'd12,
                  32'h000000F0, 1, 0, 1);
    applyStimulus(1, "L3 misLW 22", 1, 0, 0, 2'b11, 32'h22, 0, 1, 5'd13, 0, 0, 1, -1);

    // Reset in the middle of a pending store must abort it.
    setInputs(1, 0, 1, 0, 2'b11, 32'h20, 32'h0BADBEEF, 0, 5'd0);
    @(posedge clk);
    #1;
    checkOutput("rst mid stall entered", bus3.o_stall, 1);
    @(posedge clk);
    #1;
    rst3_n = 1'b0;
    #1;
    checkResetState(1, "rst mid busy");
    @(posedge clk);
    #1;
    setInputs(1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    rst3_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst aborted store", bus3.o_dbg_data, 32'hCAFEF00D);
    checkOutput("rst stall after", bus3.o_stall, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
